// File: rtl/pri_sel_pkg.sv
// Shared types and helpers for the iterative round-robin priority selector.
// Latency: n/a (types and constant/combinational functions only).
// Backpressure: n/a.
//   state_t  : selector FSM states
//   ceil_div : integer ceiling division, used to size the scan
//   digit_of : extracts one scan digit of a priority, MSB digit first
package pri_sel_pkg;

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  function automatic int ceil_div(input int a, input int b);
    return (a + b - 1) / b;
  endfunction

  // Digit 0 is the most significant one. When c is not a multiple of b the
  // top digit reads zeros above bit c-1, because value is zero-extended.
  function automatic logic [31:0] digit_of(input logic [31:0] value, input int step,
                                           input int c, input int b);
    int sh;
    sh = (ceil_div(c, b) - 1 - step) * b;
    return (value >> sh) & ((32'd1 << b) - 32'd1);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin one-hot pick: lowest set bit of mask_i at or above ptr_i, wrapping to 0.
// Latency: combinational.
// Backpressure: none.
//   mask_i   : candidate channels
//   ptr_i    : round-robin start position
//   onehot_o : chosen channel (0 when mask_i is empty)
//   idx_o    : index of chosen channel (0 when mask_i is empty)
//   any_o    : mask_i has at least one bit set
module rr_pick #(
  parameter int N  = 16,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  mask_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  onehot_o,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);

  logic [N-1:0]   upper;
  logic [2*N-1:0] dbl;
  int             sel;
  int             pos;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      upper[i] = mask_i[i] && (i >= int'(ptr_i));
    end
    // Low half holds the channels at/above ptr, high half the full mask, so
    // the lowest set bit of the double-width vector is the wrapped RR winner.
    dbl = {mask_i, upper};
    sel = 0;
    for (int j = 2 * N - 1; j >= 0; j--) begin
      if (dbl[j]) sel = j;
    end
    pos      = (sel >= N) ? sel - N : sel;
    any_o    = |mask_i;
    onehot_o = '0;
    idx_o    = '0;
    for (int i = 0; i < N; i++) begin
      if (any_o && i == pos) begin
        onehot_o[i] = 1'b1;
        idx_o       = IW'(i);
      end
    end
  end

endmodule

// File: rtl/pri_sel_rr.sv
// Iterative max-priority selector: scans B bits per cycle MSB digit first, RR tie-break.
// Latency: capture at edge T, out_valid from edge T+S+1; one result per S+1 cycles.
// Backpressure: result held stable until out_ready; in_ready=0 while scanning.
//   clk/reset          : clock, synchronous active-high reset
//   in_valid/in_ready  : offer/accept of in_pri (N channels x C bits, 0 = idle)
//   out_valid/out_ready: result handshake
//   grant/grant_idx    : one-hot winner and its index
//   max_pri/survivors  : winning priority and every channel holding it
//   no_req             : all captured priorities were zero
module pri_sel_rr
  import pri_sel_pkg::*;
#(
  parameter int N = 16,
  parameter int P = 32,
  parameter int C = $clog2(P),
  parameter int B = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [N-1:0][C-1:0]   in_pri,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [N-1:0]          grant,
  output logic [$clog2(N)-1:0]  grant_idx,
  output logic [C-1:0]          max_pri,
  output logic [N-1:0]          survivors,
  output logic                  no_req
);

  localparam int S  = ceil_div(C, B);
  localparam int IW = $clog2(N);
  localparam int SW = $clog2(S + 1);
  localparam int AW = S * B;

  state_t               state_q, state_d;
  logic [SW-1:0]        step_q, step_d;
  logic [N-1:0][C-1:0]  pri_q, pri_d;
  logic [N-1:0]         cand_q, cand_d;
  logic [AW-1:0]        acc_q, acc_d;
  logic [IW-1:0]        ptr_q, ptr_d;
  logic [N-1:0]         grant_q, grant_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [C-1:0]         max_q, max_d;
  logic [N-1:0]         surv_q, surv_d;
  logic                 noreq_q, noreq_d;

  logic [B-1:0]         dig [N];
  logic [B-1:0]         max_dig;
  logic [N-1:0]         keep;
  logic [N-1:0]         pick_oh;
  logic [IW-1:0]        pick_idx;
  logic                 pick_any;
  logic                 capture;

  // Narrow the candidate set on the current digit.
  always_comb begin
    max_dig = '0;
    for (int i = 0; i < N; i++) begin
      dig[i] = B'(digit_of(32'(pri_q[i]), int'(step_q), C, B));
      if (cand_q[i] && dig[i] > max_dig) max_dig = dig[i];
    end
    for (int i = 0; i < N; i++) begin
      keep[i] = cand_q[i] && (dig[i] == max_dig);
    end
  end

  // The pick runs on the registered final mask in its own cycle, keeping the
  // digit compare chain and the priority encoder out of series.
  rr_pick #(.N(N)) u_pick (
    .mask_i  (cand_q),
    .ptr_i   (ptr_q),
    .onehot_o(pick_oh),
    .idx_o   (pick_idx),
    .any_o   (pick_any)
  );

  assign in_ready = (state_q == IDLE) || (state_q == DONE && out_ready);
  assign capture  = in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    pri_d   = pri_q;
    cand_d  = cand_q;
    acc_d   = acc_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    idx_d   = idx_q;
    max_d   = max_q;
    surv_d  = surv_q;
    noreq_d = noreq_q;
    case (state_q)
      SCAN: begin
        if (step_q == SW'(S)) begin
          grant_d = pick_oh;
          idx_d   = pick_idx;
          max_d   = acc_q[C-1:0];
          surv_d  = cand_q;
          noreq_d = !pick_any;
          state_d = DONE;
        end else begin
          cand_d = keep;
          acc_d  = (acc_q << B) | AW'(max_dig);
          step_d = step_q + 1'b1;
        end
      end
      DONE: begin
        if (out_ready) begin
          if (|grant_q) ptr_d = (idx_q == IW'(N - 1)) ? '0 : idx_q + 1'b1;
          state_d = IDLE;
        end
      end
      default: ;
    endcase
    // Capture from IDLE, or from DONE on the same edge as the result handshake.
    if (capture) begin
      pri_d = in_pri;
      for (int i = 0; i < N; i++) cand_d[i] = |in_pri[i];
      acc_d   = '0;
      step_d  = '0;
      state_d = SCAN;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      step_q  <= '0;
      pri_q   <= '0;
      cand_q  <= '0;
      acc_q   <= '0;
      ptr_q   <= '0;
      grant_q <= '0;
      idx_q   <= '0;
      max_q   <= '0;
      surv_q  <= '0;
      noreq_q <= 1'b0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      pri_q   <= pri_d;
      cand_q  <= cand_d;
      acc_q   <= acc_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      idx_q   <= idx_d;
      max_q   <= max_d;
      surv_q  <= surv_d;
      noreq_q <= noreq_d;
    end
  end

  assign out_valid = (state_q == DONE);
  assign grant     = grant_q;
  assign grant_idx = idx_q;
  assign max_pri   = max_q;
  assign survivors = surv_q;
  assign no_req    = noreq_q;

endmodule

// File: tb/tb_pri_sel_rr.sv
// Directed bench for pri_sel_rr: three instances (N=4, C=4) with B=1, 2 and 3.
// Latency: expected out_valid S+1 cycles after capture (5, 3, 3).
// Backpressure: exercises held results, back-to-back capture and mid-scan reset.
module tb_pri_sel_rr;

  logic            clk;
  logic            reset;
  logic [3:0][3:0] ipri;
  logic            iv   [3];
  logic            ordy [3];
  logic            ir   [3];
  logic            ov   [3];
  logic [3:0]      gr   [3];
  logic [1:0]      gi   [3];
  logic [3:0]      mp   [3];
  logic [3:0]      sv   [3];
  logic            nr   [3];

  int checks = 0;
  int fails  = 0;
  int lat [3] = '{5, 3, 3};

  pri_sel_rr #(.N(4), .P(16), .B(1)) u_b1 (
    .clk(clk), .reset(reset), .in_valid(iv[0]), .in_ready(ir[0]), .in_pri(ipri),
    .out_valid(ov[0]), .out_ready(ordy[0]), .grant(gr[0]), .grant_idx(gi[0]),
    .max_pri(mp[0]), .survivors(sv[0]), .no_req(nr[0]));

  pri_sel_rr #(.N(4), .P(16), .B(2)) u_b2 (
    .clk(clk), .reset(reset), .in_valid(iv[1]), .in_ready(ir[1]), .in_pri(ipri),
    .out_valid(ov[1]), .out_ready(ordy[1]), .grant(gr[1]), .grant_idx(gi[1]),
    .max_pri(mp[1]), .survivors(sv[1]), .no_req(nr[1]));

  pri_sel_rr #(.N(4), .P(16), .B(3)) u_b3 (
    .clk(clk), .reset(reset), .in_valid(iv[2]), .in_ready(ir[2]), .in_pri(ipri),
    .out_valid(ov[2]), .out_ready(ordy[2]), .grant(gr[2]), .grant_idx(gi[2]),
    .max_pri(mp[2]), .survivors(sv[2]), .no_req(nr[2]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  typedef struct {
    int         k;
    logic [15:0] pri;
    logic [3:0] g;
    logic [1:0] i;
    logic [3:0] m;
    logic [3:0] s;
    logic       nr;
  } vec_t;

  vec_t tbl [14];

  function automatic logic [15:0] mk(input int a0, input int a1, input int a2, input int a3);
    return {4'(a3), 4'(a2), 4'(a1), 4'(a0)};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic wait_valid(input int k, output int n);
    n = 0;
    while (!ov[k] && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic check_res(input int k, input string tag, input logic [3:0] eg,
                           input logic [1:0] ei, input logic [3:0] em,
                           input logic [3:0] es, input logic en);
    chk({tag, " grant"}, gr[k], eg);
    chk({tag, " idx"}, gi[k], ei);
    chk({tag, " max_pri"}, mp[k], em);
    chk({tag, " survivors"}, sv[k], es);
    chk({tag, " no_req"}, nr[k], en);
  endtask

  task automatic run(input int k, input logic [15:0] pri, input logic [3:0] eg,
                     input logic [1:0] ei, input logic [3:0] em, input logic [3:0] es,
                     input logic en, input string tag);
    int n;
    n = 0;
    while (!ir[k] && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    ipri  = pri;
    iv[k] = 1'b1;
    @(posedge clk); #1;
    iv[k] = 1'b0;
    ipri  = '0;
    wait_valid(k, n);
    chk({tag, " latency"}, n, lat[k]);
    check_res(k, tag, eg, ei, em, es, en);
    ordy[k] = 1'b1;
    @(posedge clk); #1;
    ordy[k] = 1'b0;
    chk({tag, " valid drop"}, ov[k], 1'b0);
  endtask

  initial begin
    int n;
    tbl[0]  = '{0, mk(5, 9, 9, 3),     4'b0010, 2'd1, 4'd9,  4'b0110, 1'b0};
    tbl[1]  = '{0, mk(5, 9, 9, 3),     4'b0100, 2'd2, 4'd9,  4'b0110, 1'b0};
    tbl[2]  = '{0, mk(5, 9, 9, 3),     4'b0010, 2'd1, 4'd9,  4'b0110, 1'b0};
    tbl[3]  = '{0, mk(0, 0, 0, 0),     4'b0000, 2'd0, 4'd0,  4'b0000, 1'b1};
    tbl[4]  = '{0, mk(0, 12, 7, 12),   4'b1000, 2'd3, 4'd12, 4'b1010, 1'b0};
    tbl[5]  = '{0, mk(7, 0, 0, 0),     4'b0001, 2'd0, 4'd7,  4'b0001, 1'b0};
    tbl[6]  = '{0, mk(15, 15, 15, 15), 4'b0010, 2'd1, 4'd15, 4'b1111, 1'b0};
    tbl[7]  = '{0, mk(0, 0, 0, 1),     4'b1000, 2'd3, 4'd1,  4'b1000, 1'b0};
    tbl[8]  = '{0, mk(8, 7, 0, 8),     4'b0001, 2'd0, 4'd8,  4'b1001, 1'b0};
    tbl[9]  = '{1, mk(0, 12, 7, 12),   4'b0010, 2'd1, 4'd12, 4'b1010, 1'b0};
    tbl[10] = '{1, mk(6, 5, 6, 4),     4'b0100, 2'd2, 4'd6,  4'b0101, 1'b0};
    tbl[11] = '{2, mk(0, 12, 7, 12),   4'b0010, 2'd1, 4'd12, 4'b1010, 1'b0};
    tbl[12] = '{2, mk(6, 5, 6, 4),     4'b0100, 2'd2, 4'd6,  4'b0101, 1'b0};
    tbl[13] = '{2, mk(0, 0, 0, 0),     4'b0000, 2'd0, 4'd0,  4'b0000, 1'b1};

    reset = 1'b1;
    ipri  = '0;
    for (int k = 0; k < 3; k++) begin
      iv[k]   = 1'b0;
      ordy[k] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("reset out_valid[%0d]", k), ov[k], 1'b0);
      chk($sformatf("reset in_ready[%0d]", k), ir[k], 1'b1);
    end
    check_res(0, "reset", 4'b0000, 2'd0, 4'd0, 4'b0000, 1'b0);

    for (int v = 0; v < 14; v++) begin
      run(tbl[v].k, tbl[v].pri, tbl[v].g, tbl[v].i, tbl[v].m, tbl[v].s, tbl[v].nr,
          $sformatf("vec%0d", v));
    end

    // Held result, in_valid ignored during scan, then back-to-back capture.
    // u_b1 pointer is 1 here.
    ipri  = mk(5, 9, 9, 3);
    iv[0] = 1'b1;
    @(posedge clk); #1;
    iv[0] = 1'b0;
    wait_valid(0, n);
    chk("hold latency", n, 5);
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      chk($sformatf("hold cyc%0d", c), {ov[0], ir[0], gr[0], gi[0], mp[0], sv[0], nr[0]},
          {1'b1, 1'b0, 4'b0010, 2'd1, 4'd9, 4'b0110, 1'b0});
    end
    ipri    = mk(8, 7, 0, 8);
    iv[0]   = 1'b1;
    ordy[0] = 1'b1;
    @(posedge clk); #1;
    ordy[0] = 1'b0;
    ipri    = mk(15, 15, 15, 15);
    chk("b2b scanning valid", ov[0], 1'b0);
    chk("b2b scanning ready", ir[0], 1'b0);
    wait_valid(0, n);
    iv[0] = 1'b0;
    chk("b2b latency", n, 5);
    check_res(0, "b2b", 4'b1000, 2'd3, 4'd8, 4'b1001, 1'b0);
    ordy[0] = 1'b1;
    @(posedge clk); #1;
    ordy[0] = 1'b0;

    // Move the pointer to 2, then reset mid-scan; the pointer must return to 0.
    run(0, mk(5, 9, 9, 3), 4'b0010, 2'd1, 4'd9, 4'b0110, 1'b0, "pre-reset");
    ipri  = mk(0, 12, 7, 12);
    iv[0] = 1'b1;
    @(posedge clk); #1;
    iv[0] = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("midreset out_valid", ov[0], 1'b0);
    chk("midreset in_ready", ir[0], 1'b1);
    check_res(0, "midreset", 4'b0000, 2'd0, 4'd0, 4'b0000, 1'b0);
    run(0, mk(5, 9, 9, 3), 4'b0010, 2'd1, 4'd9, 4'b0110, 1'b0, "post-reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
